// File: rtl/l1_line_bridge.sv
// Cache-line bridge: splits one L1 fill/writeback into LINE_WORDS single-word DRAM accesses.
// Optional critical-word-first ordering is enabled by defining L1_BRIDGE_CRIT_WORD_FIRST_EN.
module l1_line_bridge #(
    parameter int DATA_WDT   = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WDT   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr,
    input  logic [ADDR_WDT-1:0]            req_addr,
    input  logic [DATA_WDT*LINE_WORDS-1:0] req_wdata,
    output logic                           rsp_valid,
    output logic [DATA_WDT*LINE_WORDS-1:0] rsp_rdata,
    output logic                           crit_valid,
    output logic [DATA_WDT-1:0]            crit_data,
    output logic                           mem_en,
    output logic                           rd_wr,
    output logic [ADDR_WDT-1:0]            mem_addr,
    output logic [DATA_WDT-1:0]            mem_wdata,
    input  logic [DATA_WDT-1:0]            mem_rdata,
    input  logic                           mem_valid
);

    localparam int OFFW = $clog2(LINE_WORDS);
    localparam logic [OFFW-1:0] LAST = OFFW'(LINE_WORDS - 1);

`ifdef L1_BRIDGE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state, state_nx;
    logic [ADDR_WDT-1:0]    base_q;
    logic [OFFW-1:0]        start_q;
    logic                   wr_q;
    logic [OFFW-1:0]        issue_cnt;
    logic [OFFW-1:0]        ack_cnt;
    logic [DATA_WDT-1:0]    wline_q [LINE_WORDS];
    logic [DATA_WDT-1:0]    rdata_q [LINE_WORDS];
    logic [DATA_WDT-1:0]    req_words [LINE_WORDS];

    logic                   accept;
    logic [OFFW-1:0]        start_in;
    logic [ADDR_WDT-1:0]    base_in;
    logic                   last_ack;

    logic                   mem_en_d;
    logic                   rd_wr_d;
    logic [OFFW-1:0]        slot_d;
    logic [ADDR_WDT-1:0]    mem_addr_d;
    logic [DATA_WDT-1:0]    mem_wdata_d;

    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_words
        assign req_words[i] = req_wdata[i*DATA_WDT +: DATA_WDT];
        assign rsp_rdata[i*DATA_WDT +: DATA_WDT] = rdata_q[i];
    end

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);
    assign start_in  = CWF ? req_addr[OFFW-1:0] : '0;
    assign base_in   = {req_addr[ADDR_WDT-1:OFFW], {OFFW{1'b0}}};
    assign last_ack  = (state == DRAIN) && mem_valid && (ack_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = ISSUE;
            ISSUE:   if (issue_cnt == LAST) state_nx = DRAIN;
            DRAIN:   if (last_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered DRAM command; the first word is launched on the accept edge.
    always_comb begin
        mem_en_d    = 1'b0;
        rd_wr_d     = 1'b0;
        slot_d      = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (accept) begin
            slot_d      = start_in;
            mem_en_d    = 1'b1;
            rd_wr_d     = req_wr;
            mem_addr_d  = base_in | ADDR_WDT'(slot_d);
            mem_wdata_d = req_wr ? req_words[slot_d] : '0;
        end else if (state == ISSUE && issue_cnt != LAST) begin
            slot_d      = start_q + issue_cnt + OFFW'(1);
            mem_en_d    = 1'b1;
            rd_wr_d     = wr_q;
            mem_addr_d  = base_q | ADDR_WDT'(slot_d);
            mem_wdata_d = wr_q ? wline_q[slot_d] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            rd_wr     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            base_q    <= '0;
            start_q   <= '0;
            wr_q      <= 1'b0;
            issue_cnt <= '0;
            ack_cnt   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                wline_q[i] <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            mem_en    <= mem_en_d;
            rd_wr     <= rd_wr_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= last_ack;
            if (accept) begin
                base_q    <= base_in;
                start_q   <= start_in;
                wr_q      <= req_wr;
                issue_cnt <= '0;
                ack_cnt   <= '0;
                for (int i = 0; i < LINE_WORDS; i++) wline_q[i] <= req_words[i];
            end else begin
                if (state == ISSUE) issue_cnt <= issue_cnt + OFFW'(1);
                if (state != IDLE && mem_valid) begin
                    ack_cnt <= ack_cnt + OFFW'(1);
                    if (!wr_q) rdata_q[start_q + ack_cnt] <= mem_rdata;
                end
            end
        end
    end

`ifdef L1_BRIDGE_CRIT_WORD_FIRST_EN
    // The first fill ack always carries the requested word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= (state != IDLE) && mem_valid && !wr_q && (ack_cnt == '0);
            if ((state != IDLE) && mem_valid && !wr_q && (ack_cnt == '0))
                crit_data <= mem_rdata;
        end
    end
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_l1_line_bridge.sv
// Randomized bench for l1_line_bridge with a DRAM model and a line-level reference memory.
module tb_l1_line_bridge;

    localparam int DW = 64;
    localparam int LW = 4;
    localparam int AW = 32;
    localparam int OFFW = 2;
    localparam int LINE_W = DW * LW;

`ifdef L1_BRIDGE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [LINE_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_rdata;
    logic              crit_valid;
    logic [DW-1:0]     crit_data;
    logic              mem_en;
    logic              rd_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l1_line_bridge #(.DATA_WDT(DW), .LINE_WORDS(LW), .ADDR_WDT(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .mem_en(mem_en), .rd_wr(rd_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return DW'(a) + 64'h60;
    endfunction

    // DRAM model: one-cycle read latency, acks every access.
    logic [DW-1:0] dram [int unsigned];
    always @(posedge clk) begin
        mem_valid <= mem_en;
        mem_rdata <= '0;
        if (mem_en) begin
            if (rd_wr) dram[mem_addr] = mem_wdata;
            else mem_rdata <= dram.exists(mem_addr) ? dram[mem_addr] : dflt(mem_addr);
        end
    end

    // Reference memory updated at request level.
    logic [DW-1:0] ref_mem [int unsigned];
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    logic [LINE_W-1:0] exp_rsp = '0;
    bit                t_wr;
    logic [AW-1:0]     t_base;
    logic [OFFW-1:0]   t_start;
    logic [LINE_W-1:0] t_line;
    logic [DW-1:0]     t_crit;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input bit wr, input logic [AW-1:0] addr, input logic [LINE_W-1:0] line);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = line;
        t_wr    = wr;
        t_line  = line;
        t_base  = {addr[AW-1:OFFW], {OFFW{1'b0}}};
        t_start = CWF ? addr[OFFW-1:0] : '0;
        if (wr) begin
            for (int i = 0; i < LW; i++) ref_mem[t_base + AW'(i)] = line[i*DW +: DW];
        end else begin
            t_crit = ref_rd(t_base + AW'(t_start));
            for (int i = 0; i < LW; i++) exp_rsp[i*DW +: DW] = ref_rd(t_base + AW'(i));
        end
    endtask

    // Called at the negedge where the request is presented; checks cycles 1..LW+2.
    task automatic run_txn(input bit chain);
        logic [OFFW-1:0] slot;
        for (int k = 1; k <= LW + 2; k++) begin
            @(negedge clk);
            if (k == 1 && !chain) req_valid = 1'b0;
            slot = t_start + OFFW'(k - 1);
            chk("req_ready", LINE_W'(req_ready), LINE_W'(k == LW + 2));
            chk("mem_en", LINE_W'(mem_en), LINE_W'(k <= LW));
            if (k <= LW) begin
                chk("mem_addr", LINE_W'(mem_addr), LINE_W'(t_base | AW'(slot)));
                chk("rd_wr", LINE_W'(rd_wr), LINE_W'(t_wr));
                chk("mem_wdata", LINE_W'(mem_wdata), t_wr ? LINE_W'(t_line[slot*DW +: DW]) : '0);
            end
            chk("rsp_valid", LINE_W'(rsp_valid), LINE_W'(k == LW + 2));
            chk("crit_valid", LINE_W'(crit_valid), LINE_W'(CWF && !t_wr && k == 3));
            if (k == 3 && !t_wr)
                chk("crit_data", LINE_W'(crit_data), CWF ? LINE_W'(t_crit) : '0);
            if (k == LW + 2)
                chk("rsp_rdata", rsp_rdata, exp_rsp);
        end
    endtask

    initial begin
        logic [LINE_W-1:0] line;
        bit chain;
        bit wr;

        // Reset with a request pending
        req_valid = 1'b1;
        req_addr  = 32'h40;
        repeat (2) @(negedge clk);
        chk("rst_ready", LINE_W'(req_ready), 1);
        chk("rst_mem_en", LINE_W'(mem_en), 0);
        chk("rst_rsp_valid", LINE_W'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_crit_valid", LINE_W'(crit_valid), 0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed fill at 0x40
        start_req(1'b0, 32'h40, '0);
        run_txn(1'b0);
        chk("fill40_const", rsp_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        @(negedge clk);

        // Writeback 1..4 to 0x80, then fill it back
        start_req(1'b1, 32'h80, {64'd4, 64'd3, 64'd2, 64'd1});
        run_txn(1'b0);
        start_req(1'b0, 32'h80, '0);
        run_txn(1'b0);
        chk("wb80_readback", rsp_rdata, {64'd4, 64'd3, 64'd2, 64'd1});
        @(negedge clk);

        // Fill at unaligned offset 0x42
        start_req(1'b0, 32'h42, '0);
        run_txn(1'b0);
        chk("fill42_const", rsp_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        // Back-to-back fills with req_valid held high
        start_req(1'b0, 32'h41, '0);
        run_txn(1'b1);
        start_req(1'b0, 32'h4F, '0);
        run_txn(1'b0);

        // Reset pulsed in cycle 3 of a fill
        start_req(1'b0, 32'h44, '0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_mem_en", LINE_W'(mem_en), 0);
        chk("midrst_ready", LINE_W'(req_ready), 1);
        chk("midrst_rdata", rsp_rdata, 0);
        exp_rsp = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", LINE_W'(rsp_valid), 0);
            chk("midrst_idle_en", LINE_W'(mem_en), 0);
        end
        start_req(1'b0, 32'h44, '0);
        run_txn(1'b0);

        // Randomized traffic over a small address window
        chain = 1'b0;
        for (int n = 0; n < 60; n++) begin
            wr = $urandom_range(0, 1) == 1;
            for (int i = 0; i < LW; i++) line[i*DW +: DW] = {$urandom, $urandom};
            start_req(wr, AW'($urandom_range(0, 47)), line);
            chain = (n != 59) && ($urandom_range(0, 2) == 0);
            run_txn(chain);
            if (!chain) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l1_line_bridge.md
# l1_line_bridge

Cache-line transfer bridge between the L1 cache controller and the word-wide DRAM model. It accepts one line-fill or line-writeback request at a time and breaks it into LINE_WORDS back-to-back single-word DRAM accesses. It reassembles fill data from the DRAM's one-cycle-latency `mem_valid` returns and signals completion with a single-cycle response pulse. It sits directly upstream of the DRAM and drives its `mem_en`/`rd_wr`/address/write-data inputs.

## Interface
- DATA_WDT, 64, DRAM word width in bits
- LINE_WORDS, 4, words per cache line; power of two, ≥2; OFFW = log2(LINE_WORDS)
- ADDR_WDT, 32, word address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request from cache
- req_ready  out  1  high when idle; a request is accepted on `req_valid && req_ready` at a rising edge
- req_wr  in  1  1 = writeback, 0 = fill
- req_addr  in  ADDR_WDT  word address; low OFFW bits = requested word offset
- req_wdata  in  DATA_WDT*LINE_WORDS  writeback line; word i at bits [i*DATA_WDT +: DATA_WDT]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WDT*LINE_WORDS  assembled fill line, same word packing
- crit_valid  out  1  critical-word pulse (see Configuration)
- crit_data  out  DATA_WDT  critical word
- mem_en  out  1  DRAM access enable
- rd_wr  out  1  0 = read, 1 = write
- mem_addr  out  ADDR_WDT  DRAM word address
- mem_wdata  out  DATA_WDT  DRAM write data
- mem_rdata  in  DATA_WDT  DRAM read data
- mem_valid  in  1  DRAM ack, one cycle after each `mem_en`

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `req_ready` = 1.
  - On accept, latch the following, then go to ISSUE:
    - base = {req_addr[ADDR_WDT-1:OFFW], 0}
    - start offset
    - req_wr
    - req_wdata
  - Clear issue_cnt and ack_cnt.
- ISSUE:
  - `mem_en` = 1 every cycle; `rd_wr` = latched req_wr.
  - slot = (start + issue_cnt) mod LINE_WORDS; `mem_addr` = base | slot.
  - Writeback: `mem_wdata` = latched word[slot]. Fill: `mem_wdata` = 0.
  - After LINE_WORDS issues, go to DRAIN.
- Acks (ISSUE and DRAIN):
  - Each `mem_valid` increments ack_cnt.
  - Fill: ack k writes `mem_rdata` into rsp_rdata word (start + k) mod LINE_WORDS.
  - `mem_valid` is ignored in IDLE.
- DRAIN:
  - When the final ack is sampled, go to IDLE and pulse `rsp_valid` (registered).
- Slot arithmetic wraps within the line only; there is never a carry into base.
- Writeback leaves rsp_rdata unchanged. Fill data is held until the next fill overwrites it.
- Reset values: `req_ready`=1, `mem_en`=0, `rd_wr`=0, `mem_addr`=0, `mem_wdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `crit_valid`=0, `crit_data`=0; state=IDLE.
- Reset mid-transfer aborts the transfer: no `rsp_valid`, partial data cleared.

## Timing
- Accept at cycle 0. `mem_en` is high in cycles 1..LINE_WORDS. `mem_valid` arrives in cycles 2..LINE_WORDS+1.
- `rsp_valid` is high in cycle LINE_WORDS+2, the same cycle `req_ready` returns to 1.
- A new request may be accepted in the `rsp_valid` cycle; its `mem_en` then starts the next cycle.
- Fixed latency: LINE_WORDS+2 cycles from accept to `rsp_valid`, for both fill and writeback.
- `mem_en`, `rd_wr`, `mem_addr` and `mem_wdata` are registered outputs. `req_ready` = (state==IDLE).

## Configuration
- `L1_BRIDGE_CRIT_WORD_FIRST_EN` defined:
  - Fills start at the requested offset and wrap.
  - `crit_valid` pulses in the cycle after the first fill ack, with `crit_data` = that word.
  - Writebacks still start at the requested offset and never pulse `crit_valid`.
- Not defined:
  - start is always 0; issue order is base+0..LINE_WORDS-1.
  - `crit_valid`/`crit_data` are tied to 0.

## Test plan
- Reset: assert rst with a request pending -> `req_ready`=1, `mem_en`=0, `rsp_valid`=0, `rsp_rdata`=0.
- Fill at 0x40, DRAM words 0x40..0x43 = 0xA0..0xA3, LINE_WORDS=4 -> `mem_en` in cycles 1–4 at addresses 0x40..0x43, `rd_wr`=0; `rsp_valid` in cycle 6; `rsp_rdata`={A3,A2,A1,A0}.
- Writeback at 0x80 with words 1,2,3,4 -> writes to 0x80..0x83 with `rd_wr`=1 and matching `mem_wdata`; `rsp_valid` in cycle 6; a following fill at 0x80 returns {4,3,2,1}.
- Fill at req_addr 0x42:
  - Macro defined -> addresses 0x42,0x43,0x40,0x41; `crit_valid` in cycle 3 with `crit_data`=0xA2; `rsp_rdata`={A3,A2,A1,A0}.
  - Macro undefined -> addresses 0x40..0x43; `crit_valid` stays 0.
- Back-to-back: `req_valid` held high for two fills -> second accepted in cycle 6, its `mem_en` starts in cycle 7, its `rsp_valid` in cycle 12.
- Reset pulsed in cycle 3 of a fill -> `mem_en` drops immediately, no `rsp_valid`; after release `req_ready`=1 and a new fill completes with correct data.
